// File: rtl/pe_data_fetch.sv
// pe_data_fetch
//   Moves one 4-lane row between single-port synchronous data memory and the
//   PE wrapper on a fixed slot schedule.
//   Load:  the row at ADDRESS is read lane by lane and presented on DATAIN,
//          followed by a one-cycle FETCH_DONE.
//   Store: DATAOUT is captured on the start edge and written lane by lane,
//          followed by a one-cycle STORE_DONE.
//   Because the schedule never depends on the mask or the data, the control
//   unit can count cycles instead of handshaking.
//
// Ports
//   CLK, RST        clock (rising edge) / asynchronous active-high reset
//   ADDR_START      one-cycle pulse: start a row load
//   WRADDR_START    one-cycle pulse: start a row store (wins over ADDR_START)
//   ADDR_RST        synchronous abort: back to idle, DATAIN cleared
//   ADDRESS         row address, sampled with a start pulse
//   LANE_MASK       per-lane enable, sampled with a start pulse
//   DATAOUT         PE results, lane k at [k*DATA_W +: DATA_W]
//   DATAIN          loaded row to the PEs, same packing
//   FETCH_DONE      one-cycle pulse once DATAIN holds the complete row
//   STORE_DONE      one-cycle pulse once the row has been written
//   BUSY            operation in progress (including its done cycle)
//   MEM_ADDR        memory word address {row, lane}; 0 outside slots
//   MEM_RE/MEM_WE   read / write enables
//   MEM_WDATA       write data
//   MEM_RDATA       read data, valid the cycle after MEM_RE
module pe_data_fetch #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int LANES  = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    ADDR_START,
  input  logic                    WRADDR_START,
  input  logic                    ADDR_RST,
  input  logic [ADDR_W-1:0]       ADDRESS,
  input  logic [3:0]              LANE_MASK,
  input  logic [LANES*DATA_W-1:0] DATAOUT,
  output logic [LANES*DATA_W-1:0] DATAIN,
  output logic                    FETCH_DONE,
  output logic                    STORE_DONE,
  output logic                    BUSY,
  output logic [ADDR_W+1:0]       MEM_ADDR,
  output logic                    MEM_RE,
  output logic                    MEM_WE,
  output logic [DATA_W-1:0]       MEM_WDATA,
  input  logic [DATA_W-1:0]       MEM_RDATA
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    STORE = 2'd2
  } state_t;

  state_t              state_reg, state_next;
  // Load uses slots 0..4: 0..3 issue reads, 4 only captures the last lane.
  // Store uses slots 0..3.
  logic [2:0]          slot_reg, slot_next;
  logic [ADDR_W-1:0]   addr_reg;
  logic [3:0]          mask_reg;
  logic [DATA_W-1:0]   wbuf_reg   [LANES];
  logic [DATA_W-1:0]   datain_reg [LANES];
  logic                fetch_done_reg;
  logic                store_done_reg;

  logic                start_store;
  logic                start_load;
  logic [1:0]          lane_sel;

  // Starts are only looked at in IDLE; the abort beats both, store beats load.
  assign start_store = (state_reg == IDLE) && !ADDR_RST && WRADDR_START;
  assign start_load  = (state_reg == IDLE) && !ADDR_RST && !WRADDR_START && ADDR_START;
  assign lane_sel    = slot_reg[1:0];

  // ---------------- state register ----------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg <= IDLE;
      slot_reg  <= 3'd0;
    end else begin
      state_reg <= state_next;
      slot_reg  <= slot_next;
    end
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_next = state_reg;
    slot_next  = slot_reg;
    if (ADDR_RST) begin
      state_next = IDLE;
      slot_next  = 3'd0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          slot_next = 3'd0;
          if (start_store)     state_next = STORE;
          else if (start_load) state_next = LOAD;
        end
        LOAD: begin
          if (slot_reg == 3'd4) begin
            state_next = IDLE;
            slot_next  = 3'd0;
          end else begin
            slot_next = slot_reg + 3'd1;
          end
        end
        STORE: begin
          if (slot_reg == 3'd3) begin
            state_next = IDLE;
            slot_next  = 3'd0;
          end else begin
            slot_next = slot_reg + 3'd1;
          end
        end
        default: begin
          state_next = IDLE;
          slot_next  = 3'd0;
        end
      endcase
    end
  end

  // ---------------- output logic ----------------
  // Memory strobes are decoded straight from the slot so that an abort or
  // reset drops them in the same cycle.
  always_comb begin
    MEM_ADDR  = '0;
    MEM_RE    = 1'b0;
    MEM_WE    = 1'b0;
    MEM_WDATA = '0;
    if (state_reg == LOAD && slot_reg != 3'd4) begin
      MEM_ADDR = {addr_reg, lane_sel};
      MEM_RE   = mask_reg[lane_sel];
    end else if (state_reg == STORE) begin
      MEM_ADDR  = {addr_reg, lane_sel};
      MEM_WE    = mask_reg[lane_sel];
      MEM_WDATA = wbuf_reg[lane_sel];
    end
  end

  assign FETCH_DONE = fetch_done_reg;
  assign STORE_DONE = store_done_reg;
  // The done cycle is already IDLE (so a new start can land on its closing
  // edge) but still counts as busy for the control unit.
  assign BUSY = (state_reg != IDLE) || fetch_done_reg || store_done_reg;

  // ---------------- control datapath ----------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      addr_reg       <= '0;
      mask_reg       <= '0;
      fetch_done_reg <= 1'b0;
      store_done_reg <= 1'b0;
    end else begin
      fetch_done_reg <= !ADDR_RST && (state_reg == LOAD)  && (slot_reg == 3'd4);
      store_done_reg <= !ADDR_RST && (state_reg == STORE) && (slot_reg == 3'd3);
      if (start_store || start_load) begin
        addr_reg <= ADDRESS;
        mask_reg <= LANE_MASK;
      end
    end
  end

  // ---------------- per-lane registers ----------------
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      // Read data for lane gi arrives one slot after its read slot, so it is
      // captured at the end of slot gi+1. Masked lanes load zero.
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          datain_reg[gi] <= '0;
        end else if (ADDR_RST) begin
          datain_reg[gi] <= '0;
        end else if (state_reg == LOAD && slot_reg == 3'(gi + 1)) begin
          datain_reg[gi] <= mask_reg[gi] ? MEM_RDATA : '0;
        end
      end

      // Store data is frozen on the start edge; DATAOUT is free afterwards.
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          wbuf_reg[gi] <= '0;
        end else if (start_store) begin
          wbuf_reg[gi] <= DATAOUT[gi*DATA_W +: DATA_W];
        end
      end

      assign DATAIN[gi*DATA_W +: DATA_W] = datain_reg[gi];
    end
  endgenerate

endmodule

// File: doc/pe_data_fetch.md
Name: pe_data_fetch

Overview:
Data-fetch/store unit between data memory and the control-unit/PE wrapper. On ADDR_START it reads one 4-lane row from single-port synchronous memory and presents it on DATAIN with a FETCH_DONE pulse. On WRADDR_START it snapshots the PE results on DATAOUT and writes them back, then pulses STORE_DONE. Fixed-latency slot schedule, so control-unit timing is deterministic.

Parameters:
DATA_W, 32, lane word width
ADDR_W, 4, row address width; memory word address is {ADDRESS, lane[1:0]}
LANES, 4, PE lane count; fixed at 4 (lane index is 2 bits)

Ports:
CLK  in  1  clock, all state on rising edge
RST  in  1  asynchronous, active-high reset
ADDR_START  in  1  one-cycle pulse: begin row load
WRADDR_START  in  1  one-cycle pulse: begin row store
ADDR_RST  in  1  synchronous abort/clear
ADDRESS  in  ADDR_W  row address, sampled with ADDR_START/WRADDR_START
LANE_MASK  in  4  per-lane enable, sampled with the start pulse
DATAOUT  in  LANES*DATA_W  PE results, lane k = bits [k*DATA_W +: DATA_W]
DATAIN  out  LANES*DATA_W  loaded row to PEs, same packing
FETCH_DONE  out  1  one-cycle pulse: DATAIN updated
STORE_DONE  out  1  one-cycle pulse: row written
BUSY  out  1  high while a load or store is in progress
MEM_ADDR  out  ADDR_W+2  memory word address
MEM_RE  out  1  read enable; MEM_RDATA valid on the cycle after
MEM_WE  out  1  write enable
MEM_WDATA  out  DATA_W  write data
MEM_RDATA  in  DATA_W  read data, 1-cycle latency

Behaviour:
- Reset (RST=1, async): state IDLE; all outputs 0; DATAIN=0; internal address, mask and write buffer cleared.
- States: IDLE, LOAD (slot counter 0..3 issue, capture pipeline), STORE (slot 0..3).
- Start acceptance: only in IDLE. Start pulses while BUSY are ignored. If both starts are high in IDLE, WRADDR_START wins and ADDR_START is dropped.
- Load, with ADDR_START sampled at edge E0:
  - Slot k (k=0..3) occupies the cycle after edge Ek. In that slot MEM_ADDR={addr,k} and MEM_RE=mask[k].
  - Lane k of DATAIN is written at edge E(k+2): MEM_RDATA if mask[k], else 0.
  - FETCH_DONE is registered at E5, so it is high for the one cycle after E5. BUSY is high from after E0 through the FETCH_DONE cycle.
  - Latency is fixed at 5 cycles regardless of mask. Mask=0000 still takes 5 cycles and yields DATAIN=0.
- DATAIN holds its value between loads. During a load, each lane is updated at its own edge, so DATAIN is only fully coherent once FETCH_DONE is high.
- Store, with WRADDR_START sampled at edge E0:
  - DATAOUT and the mask are snapshotted at E0; later DATAOUT changes have no effect.
  - Slot k is the cycle after Ek: MEM_ADDR={addr,k}, MEM_WDATA=buffered lane k, MEM_WE=mask[k].
  - STORE_DONE is registered at E4, so it is high for the one cycle after E4.
  - MEM_RE=0 throughout a store; MEM_WE=0 outside store slots.
- ADDR_RST=1 at an edge (any state):
  - Go to IDLE, clear DATAIN to 0, deassert MEM_RE/MEM_WE and BUSY from the next cycle.
  - No FETCH_DONE or STORE_DONE is emitted for the aborted operation.
  - ADDR_RST has priority over a start pulse on the same edge.
- MEM_ADDR is 0 when no slot is active.
- A new start is accepted on the edge that ends the done-pulse cycle (state is IDLE during the done cycle). This gives back-to-back throughput of one operation per 6 load cycles or 5 store cycles.

Test Plan:
- Memory preloaded with row 2 = {23,63,56,78} at lanes 0..3; ADDR_START with ADDRESS=2, mask=1111 -> MEM_RE at word addresses 8,9,10,11 on consecutive cycles; DATAIN={23,63,56,78}; FETCH_DONE high exactly 5 cycles after the start edge, for 1 cycle.
- Same load with mask=0101 -> MEM_RE only on addresses 8 and 10; DATAIN lane0=23, lane1=0, lane2=56, lane3=0; FETCH_DONE still at +5.
- DATAOUT={42,93,14,7}, WRADDR_START with ADDRESS=3, mask=1111, then DATAOUT changed to 0 the next cycle -> writes 42,93,14,7 to addresses 12..15; STORE_DONE at +4; memory readback matches.
- ADDR_START pulsed during a store and during a load -> ignored; no extra memory traffic; exactly one done pulse per accepted operation.
- ADDR_RST asserted in load slot 2 -> BUSY=0 and DATAIN=0 next cycle; no FETCH_DONE; a subsequent load completes normally. Repeat with async RST mid-store -> all outputs 0 immediately.
- ADDR_START and WRADDR_START on the same edge -> store executes; no reads issued.
